// File: rtl/pixel_readout_ctrl.sv
// Frame sequencer for a NUM_PIXELS pixel array: erase, exposure, ramp conversion, streamed readout.
// Optional build macro SAT_FLAG_EN adds the out_sat / sat_count saturation reporting ports.
module pixel_readout_ctrl #(
    parameter int NUM_PIXELS   = 4,
    parameter int DATA_W       = 8,
    parameter int ERASE_CYCLES = 5,
    parameter int EXP_W        = 16,
    localparam int IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1,
    localparam int SAT_W = $clog2(NUM_PIXELS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [EXP_W-1:0]      expose_len,
    output logic                  erase,
    output logic                  expose,
    output logic                  convert,
    output logic [NUM_PIXELS-1:0] read,
    output logic                  ana_bias,
    output logic                  ana_ramp,
    inout  wire  [DATA_W-1:0]     pix_data,
    output logic [DATA_W-1:0]     out_data,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  frame_done
`ifdef SAT_FLAG_EN
    ,
    output logic                  out_sat,
    output logic [SAT_W-1:0]      sat_count
`endif
);

    localparam int TMR_W = (EXP_W > $clog2(ERASE_CYCLES + 1)) ? EXP_W : $clog2(ERASE_CYCLES + 1);
    localparam logic [NUM_PIXELS-1:0] READ_ONE = NUM_PIXELS'(1);

    typedef enum logic [2:0] {S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READ, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [EXP_W-1:0]    exp_q, exp_d;
    logic [DATA_W-1:0]   ramp_q, ramp_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [IDX_W-1:0]    out_idx_q, out_idx_d;
    logic                out_valid_q, out_valid_d;
    logic                frame_done_q, frame_done_d;
    logic                erase_q, erase_d;
    logic                expose_q, expose_d;
    logic                convert_q, convert_d;
    logic                busy_q, busy_d;
    logic                capture_s;
    logic [EXP_W-1:0]    exp_len_s;
    logic [NUM_PIXELS-1:0] read_s;
`ifdef SAT_FLAG_EN
    logic                out_sat_q, out_sat_d;
    logic [SAT_W-1:0]    sat_count_q, sat_count_d;
`endif

    // A pixel is strobed only when the output register can take its code this cycle.
    assign capture_s = (state_q == S_READ) && (!out_valid_q || out_ready);
    assign exp_len_s = (expose_len == '0) ? EXP_W'(1) : expose_len;
    assign read_s    = capture_s ? (READ_ONE << idx_q) : '0;
    assign pix_data  = (read_s == '0) ? ramp_q : {DATA_W{1'bz}};

    // Next-state, timers, ramp and output-stream handshake.
    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        exp_d        = exp_q;
        ramp_d       = '0;
        idx_d        = idx_q;
        out_data_d   = out_data_q;
        out_idx_d    = out_idx_q;
        out_valid_d  = out_valid_q;
        frame_done_d = 1'b0;
`ifdef SAT_FLAG_EN
        out_sat_d    = out_sat_q;
        sat_count_d  = sat_count_q;
`endif
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ERASE;
                    exp_d   = exp_len_s;
                    tmr_d   = TMR_W'(ERASE_CYCLES - 1);
                    idx_d   = '0;
`ifdef SAT_FLAG_EN
                    sat_count_d = '0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERASE: begin
                if (tmr_q == '0) begin
                    state_d = S_EXPOSE;
                    tmr_d   = TMR_W'(exp_q) - TMR_W'(1);
                end else begin
                    tmr_d   = tmr_q - TMR_W'(1);
                end
            end
            S_EXPOSE: begin
                if (tmr_q == '0) begin
                    state_d = S_CONVERT;
                end else begin
                    tmr_d   = tmr_q - TMR_W'(1);
                end
            end
            S_CONVERT: begin
                if (ramp_q == {DATA_W{1'b1}}) begin
                    state_d = S_READ;
                end else begin
                    ramp_d  = ramp_q + DATA_W'(1);
                end
            end
            S_READ: begin
                if (capture_s) begin
                    out_data_d  = pix_data;
                    out_idx_d   = idx_q;
                    out_valid_d = 1'b1;
`ifdef SAT_FLAG_EN
                    out_sat_d   = (pix_data == {DATA_W{1'b1}});
                    if (pix_data == {DATA_W{1'b1}}) begin
                        sat_count_d = sat_count_q + SAT_W'(1);
                    end else begin
                        sat_count_d = sat_count_q;
                    end
`endif
                    if (idx_q == IDX_W'(NUM_PIXELS - 1)) begin
                        state_d      = S_DONE;
                        frame_done_d = 1'b1;
                        idx_d        = '0;
                    end else begin
                        idx_d        = idx_q + IDX_W'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        erase_d   = (state_d == S_ERASE);
        expose_d  = (state_d == S_EXPOSE);
        convert_d = (state_d == S_CONVERT);
        busy_d    = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            tmr_q        <= '0;
            exp_q        <= '0;
            ramp_q       <= '0;
            idx_q        <= '0;
            out_data_q   <= '0;
            out_idx_q    <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            erase_q      <= 1'b0;
            expose_q     <= 1'b0;
            convert_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SAT_FLAG_EN
            out_sat_q    <= 1'b0;
            sat_count_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            exp_q        <= exp_d;
            ramp_q       <= ramp_d;
            idx_q        <= idx_d;
            out_data_q   <= out_data_d;
            out_idx_q    <= out_idx_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            erase_q      <= erase_d;
            expose_q     <= expose_d;
            convert_q    <= convert_d;
            busy_q       <= busy_d;
`ifdef SAT_FLAG_EN
            out_sat_q    <= out_sat_d;
            sat_count_q  <= sat_count_d;
`endif
        end
    end

    assign erase      = erase_q;
    assign expose     = expose_q;
    assign convert    = convert_q;
    assign read       = read_s;
    assign ana_bias   = expose_q & clk;
    assign ana_ramp   = convert_q & clk;
    assign out_data   = out_data_q;
    assign out_idx    = out_idx_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
`ifdef SAT_FLAG_EN
    assign out_sat    = out_sat_q;
    assign sat_count  = sat_count_q;
`endif

endmodule

// File: doc/pixel_readout_ctrl.md
Name: pixel_readout_ctrl

Overview:
Parametrised successor to the fixed four-pixel top-level controller. Sequences one frame over a NUM_PIXELS pixel array: erase, programmable exposure, ramp conversion and per-pixel readout. During conversion it drives a DATA_W-bit ramp count onto the shared tristate pixel bus. During readout it captures each pixel's latched code and delivers it downstream over a valid/ready stream with backpressure, replacing the earlier file-dump readout.

Parameters:
NUM_PIXELS, 4, number of pixels / read strobes (1..64)
DATA_W, 8, ramp counter and pixel code width (4..12)
ERASE_CYCLES, 5, cycles erase is held high (>=1)
EXP_W, 16, width of the exposure length input

Ports:
clk  in  1  system clock; also gated onto the analog ramp/bias outputs
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle frame request; honoured only in IDLE
expose_len  in  EXP_W  exposure length in cycles, latched on an accepted start; 0 is treated as 1
erase  out  1  pixel erase strobe
expose  out  1  pixel expose strobe
convert  out  1  high during the ramp conversion
read  out  NUM_PIXELS  one-hot pixel read strobes
ana_bias  out  1  expose & clk
ana_ramp  out  1  convert & clk
pix_data  inout  DATA_W  shared tristate pixel bus
out_data  out  DATA_W  captured pixel code
out_idx  out  clog2(NUM_PIXELS) (min 1)  index of the pixel in out_data
out_valid  out  1  out_data/out_idx valid
out_ready  in  1  downstream accept
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse when the last pixel is captured

Behaviour:
- While reset=0 at a posedge:
  - state returns to IDLE; this aborts any frame in progress.
  - ramp counter, pixel index, out_data, out_idx, out_valid and frame_done all clear to 0.
  - erase, expose, convert and read are all 0.
  - Reset has priority over every other input.
- FSM states: IDLE, ERASE, EXPOSE, CONVERT, READ, DONE.
- IDLE:
  - start=1 moves to ERASE on the next cycle and latches max(expose_len,1).
  - start in any other state is ignored.
- ERASE: erase=1 for exactly ERASE_CYCLES cycles, then EXPOSE.
- EXPOSE: expose=1 for exactly the latched length, then CONVERT.
- CONVERT: convert=1 for exactly 2^DATA_W cycles.
  - The ramp counter is 0 in the first CONVERT cycle and increments by 1 each cycle, reaching 2^DATA_W-1 in the last cycle. It never wraps.
  - Outside CONVERT the counter is held at 0.
- Bus drive: pix_data = counter whenever no read bit is set; otherwise high-Z. This block never drives the bus while any read bit is high.
- READ, with pixel index k starting at 0:
  - read[k] is asserted in a cycle only when the output slot is free, i.e. (!out_valid || out_ready). This is a combinational dependency on out_ready.
  - At the end of that cycle: out_data <= pix_data, out_idx <= k, out_valid <= 1, k <= k+1.
  - While the slot is not free, read=0 and k holds (backpressure stall, any length).
  - After capturing k = NUM_PIXELS-1, go to DONE.
- DONE: frame_done=1 for one cycle, then IDLE.
- Output handshake:
  - A transfer occurs when out_valid & out_ready.
  - out_valid falls after a transfer unless a new capture happens in the same cycle.
  - out_data and out_idx stay stable while out_valid=1 and out_ready=0.
  - A beat still pending when the FSM returns to IDLE stays valid until accepted.
  - A new frame may start while a beat is pending; its first capture stalls until the slot frees.
- Latency with out_ready tied 1: start accepted at cycle 0. First read at cycle 1 + ERASE_CYCLES + exp + 2^DATA_W. One pixel per cycle after that, then frame_done one cycle after the last capture.
- No X is ever driven on out_data. Undriven bus bits are captured as-is; the bench checks that they are never Z.

Optional Feature:
SAT_FLAG_EN:
- When defined, adds output out_sat (1 bit), registered alongside out_data. It is 1 when the captured code equals 2^DATA_W-1, marking a pixel that never tripped during the ramp.
- Adds output sat_count (clog2(NUM_PIXELS+1) bits) holding the number of saturated pixels in the current frame. It clears on an accepted start and on reset.
- When not defined, neither port exists and there is no added logic.

Test Plan:
1. Defaults, out_ready=1, expose_len=3, array model returns codes 10,20,30,40 -> erase high 5 cycles, expose high 3, convert high 256. Four beats with idx 0..3 and data 10,20,30,40 on consecutive cycles. frame_done one cycle after the 4th beat; busy low the cycle after that.
2. expose_len=0 -> expose is high exactly 1 cycle.
3. Backpressure: out_ready low for 7 cycles after the first beat -> read stays 0 and beat 0 holds idx=0/data=10. Remaining beats follow at the rate out_ready allows, with no loss or duplication.
4. Bus contention: monitor every cycle -> pix_data is never driven by both sides. During CONVERT the bus value increments 0..255 with no wrap.
5. Reset mid-CONVERT (counter=100), then reset deasserted -> IDLE; all outputs 0, bus counter 0. A new start runs a full clean frame.
6. SAT_FLAG_EN defined, DATA_W=6, NUM_PIXELS=8, pixels 2 and 5 never trip -> out_sat=1 exactly on beats idx 2 and 5 (data 63); sat_count=2 at frame_done.
